sonar_scan_sequencer: RTL and testbench
=======================================

// Module: sonar_scan_sequencer
// PURPOSE
// - Parametrised ping scheduler and angle sweeper that replaces the fixed single-angle burst/listen timing.
// - Steps beam_angle_out across [ANGLE_MIN, ANGLE_MAX]. Each angle runs settle -> burst -> listen.
// - Captures the first qualified echo time per angle and streams (angle, tof, hit) records over a valid/ready interface.
// - Sits between the sin LUT / beamformers / SPI front end and the range, velocity and display logic.
// PARAMETERS
// - ANGLE_WIDTH    8      signed beam angle width, degrees off boresight
// - ANGLE_MIN      -30    first angle of a sweep
// - ANGLE_MAX      30     last angle of a sweep; (ANGLE_MAX-ANGLE_MIN) % ANGLE_STEP == 0
// - ANGLE_STEP     10     angle increment, >0
// - SETTLE_CYCLES  16     idle cycles after each angle change before the burst
// - BURST_CYCLES   524288 transmit burst length in clocks
// - LISTEN_CYCLES  2**23  receive window length in clocks
// - BLANK_CYCLES   4096   echoes ignored for this many clocks after the burst ends (ringdown)
// - SAMPLE_WIDTH   16     aggregated waveform magnitude width (unsigned)
// - TIMER_WIDTH    $clog2(BURST_CYCLES+LISTEN_CYCLES+1)
// PORTS
// - clk_in                    in   1            system clock (100 MHz)
// - rst_n                     in   1            asynchronous reset, active low
// - enable_in                 in   1            level; high = keep sweeping
// - sample_in                 in   SAMPLE_WIDTH aggregated receive magnitude
// - sample_valid_in           in   1            sample_in qualifier
// - threshold_in              in   SAMPLE_WIDTH echo threshold, sampled at each burst start
// - beam_angle_out            out  ANGLE_WIDTH  signed current steering angle
// - burst_active_out          out  1            gate for the transmitter outputs
// - listen_active_out         out  1            receive window open
// - frontend_rst_out          out  1            1-cycle pulse, first BURST cycle
// - time_since_emission_out   out  TIMER_WIDTH  clocks since burst start
// - result_valid_out          out  1            record available
// - result_ready_in           in   1            consumer accepts record
// - result_angle_out          out  ANGLE_WIDTH  angle of record
// - result_tof_out            out  TIMER_WIDTH  echo time (clocks since burst start); 0 on miss
// - result_hit_out            out  1            1 = echo found
// - sweep_done_out            out  1            1-cycle pulse when the end-of-sweep record is accepted
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - FSM=IDLE; beam_angle_out=ANGLE_MIN.
//   - All other outputs, the timer and the latched threshold are 0.
//   - Reset mid-operation aborts immediately; a pending record is lost.
// - FSM states: IDLE, SETTLE, BURST, LISTEN, REPORT.
// - IDLE: when enable_in=1 -> SETTLE next cycle; the angle is kept.
// - SETTLE: holds exactly SETTLE_CYCLES cycles -> BURST.
// - BURST:
//   - First cycle: timer=0, frontend_rst_out=1, threshold latched.
//   - burst_active_out=1 for exactly BURST_CYCLES cycles.
//   - The timer increments every cycle from BURST entry to LISTEN exit.
// - LISTEN:
//   - listen_active_out=1 for exactly LISTEN_CYCLES cycles (timer BURST_CYCLES .. BURST_CYCLES+LISTEN_CYCLES-1).
//   - Qualified echo: sample_valid_in && sample_in > threshold_in && timer >= BURST_CYCLES+BLANK_CYCLES.
//   - The first qualified echo latches tof=timer and hit=1. Later echoes are ignored.
//   - The window always runs full length (fixed ping rate).
//   - An echo on the last LISTEN cycle counts.
// - REPORT:
//   - result_valid_out=1 one cycle after LISTEN ends; the record is stable while valid.
//   - The record clears on the valid&&ready cycle. Ready low stalls the FSM (no new burst).
// - Advance on accept:
//   - Angle += ANGLE_STEP.
//   - At ANGLE_MAX: wrap to ANGLE_MIN and pulse sweep_done_out with the accept.
//   - Then SETTLE if enable_in=1, else IDLE.
//   - Deasserting enable_in mid-ping finishes and reports the current angle first.
// - Single-angle config (ANGLE_MIN==ANGLE_MAX): every accept pulses sweep_done_out.
// - Angle arithmetic is done signed at ANGLE_WIDTH+1 bits; no overflow for legal parameters.
// CONFIGURATION
// - SCAN_PINGPONG_EN defined:
//   - Sweep reverses direction at each end; the end angle is not repeated.
//   - Order is MIN..MAX, MAX-STEP..MIN, MIN+STEP..MAX.
//   - sweep_done_out pulses at both ends.
// - SCAN_PINGPONG_EN undefined: sawtooth order MIN..MAX, MIN..MAX.
// TESTING (ANGLE -30..30 step 10, SETTLE=2, BURST=8, LISTEN=64, BLANK=4, threshold=5000)
// - Reset then enable=1, ready=1, no echo:
//   - 7 records, angles -30,-20,...,30, all hit=0/tof=0.
//   - burst_active high 8 cycles per ping; sweep_done pulses once after angle 30.
// - Samples 6000 at timer 10 (blanked), 12 and 20:
//   - Record hit=1, tof=12.
//   - Repeat with samples 5000 (not >threshold) -> hit=0.
// - Hold ready=0 for 50 cycles in REPORT:
//   - Record stable; no frontend_rst_out pulse; burst_active stays low.
//   - Then ready=1 -> accept, next burst follows 2 SETTLE cycles later.
// - Drop enable at timer 30 of angle 0:
//   - Angle-0 record is still produced; after accept FSM=IDLE with beam_angle=10.
// - Assert rst_n=0 mid-LISTEN:
//   - All outputs 0 asynchronously; angle=-30.
//   - After release with enable=1, the sweep restarts at -30.
// - With SCAN_PINGPONG_EN: 13 accepts give 30 after 7 records, then -30 at record 13.
//   - sweep_done pulses at records 7 and 13.

Source files
------------

// File: rtl/sonar_scan_sequencer.sv
// ---------------------------------------------------------------------------
// sonar_scan_sequencer
//
// Ping scheduler and beam-angle sweeper. For every steering angle in
// [ANGLE_MIN, ANGLE_MAX] it runs SETTLE -> BURST -> LISTEN. It captures the
// first qualified echo time of the ping, then offers an (angle, tof, hit)
// record on a valid/ready port. Accepting the record advances the angle.
//
// Optional build macro:
//   SCAN_PINGPONG_EN  - sweep reverses at each end instead of wrapping
//                       (MIN..MAX, MAX-STEP..MIN, ...); sweep_done_out pulses
//                       at both ends.
//
// Ports:
//   clk_in, rst_n            clock, asynchronous active-low reset
//   enable_in                level, keep sweeping while high
//   sample_in/_valid_in      aggregated receive magnitude and its qualifier
//   threshold_in             echo threshold, captured on the first BURST cycle
//   beam_angle_out           signed current steering angle
//   burst_active_out         transmitter gate
//   listen_active_out        receive window open
//   frontend_rst_out         one-cycle pulse on the first BURST cycle
//   time_since_emission_out  clocks since burst start
//   result_*                 record stream (valid/ready handshake)
//   sweep_done_out           pulses with the accept of an end-of-sweep record
// ---------------------------------------------------------------------------
module sonar_scan_sequencer #(
  parameter int ANGLE_WIDTH   = 8,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int BURST_CYCLES  = 524288,
  parameter int LISTEN_CYCLES = 2**23,
  parameter int BLANK_CYCLES  = 4096,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int TIMER_WIDTH   = $clog2(BURST_CYCLES + LISTEN_CYCLES + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  input  logic                          sample_valid_in,
  input  logic [SAMPLE_WIDTH-1:0]       threshold_in,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          burst_active_out,
  output logic                          listen_active_out,
  output logic                          frontend_rst_out,
  output logic [TIMER_WIDTH-1:0]        time_since_emission_out,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [TIMER_WIDTH-1:0]        result_tof_out,
  output logic                          result_hit_out,
  output logic                          sweep_done_out
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] BURST_LAST  = TIMER_WIDTH'(BURST_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] LISTEN_LAST = TIMER_WIDTH'(BURST_CYCLES + LISTEN_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] BLANK_END   = TIMER_WIDTH'(BURST_CYCLES + BLANK_CYCLES);

  localparam logic signed [ANGLE_WIDTH-1:0] AMIN     = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] AMAX     = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH:0]   STEP_POS = (ANGLE_WIDTH + 1)'(ANGLE_STEP);
`ifdef SCAN_PINGPONG_EN
  localparam logic signed [ANGLE_WIDTH:0]   STEP_NEG = (ANGLE_WIDTH + 1)'(-ANGLE_STEP);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_BURST,
    S_LISTEN,
    S_REPORT
  } state_t;

  // Angle step done one bit wider so the intermediate sum cannot wrap.
  function automatic logic signed [ANGLE_WIDTH-1:0] step_angle(
    input logic signed [ANGLE_WIDTH-1:0] a,
    input logic signed [ANGLE_WIDTH:0]   d
  );
    logic signed [ANGLE_WIDTH:0] s;
    s = $signed({a[ANGLE_WIDTH-1], a}) + d;
    return s[ANGLE_WIDTH-1:0];
  endfunction

  state_t                          state_q, state_d;
  logic [SETTLE_W-1:0]             settle_q, settle_d;
  logic [TIMER_WIDTH-1:0]          timer_q, timer_d;
  logic [SAMPLE_WIDTH-1:0]         thr_q, thr_d;
  logic [TIMER_WIDTH-1:0]          tof_q, tof_d;
  logic                            hit_q, hit_d;
  logic signed [ANGLE_WIDTH-1:0]   angle_q, angle_d;
`ifdef SCAN_PINGPONG_EN
  logic                            dir_up_q, dir_up_d;
`endif
  logic                            sweep_done;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    timer_d    = timer_q;
    thr_d      = thr_q;
    tof_d      = tof_q;
    hit_d      = hit_q;
    angle_d    = angle_q;
`ifdef SCAN_PINGPONG_EN
    dir_up_d   = dir_up_q;
`endif
    sweep_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_BURST;
          timer_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end

      S_BURST: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        if (timer_q == '0) begin
          thr_d = threshold_in;
          tof_d = '0;
          hit_d = 1'b0;
        end
        if (timer_q == BURST_LAST) begin
          state_d = S_LISTEN;
        end
      end

      S_LISTEN: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        // Only the first echo past the ringdown blank is kept; the window
        // still runs to full length so the ping rate stays fixed.
        if (!hit_q && sample_valid_in && (sample_in > thr_q) && (timer_q >= BLANK_END)) begin
          tof_d = timer_q;
          hit_d = 1'b1;
        end
        if (timer_q == LISTEN_LAST) begin
          state_d = S_REPORT;
          timer_d = '0;
        end
      end

      S_REPORT: begin
        if (result_ready_in) begin
          tof_d    = '0;
          hit_d    = 1'b0;
          settle_d = '0;
          state_d  = enable_in ? S_SETTLE : S_IDLE;
`ifdef SCAN_PINGPONG_EN
          if (ANGLE_MIN == ANGLE_MAX) begin
            sweep_done = 1'b1;
          end else if (dir_up_q) begin
            if (angle_q == AMAX) begin
              angle_d    = step_angle(angle_q, STEP_NEG);
              dir_up_d   = 1'b0;
              sweep_done = 1'b1;
            end else begin
              angle_d = step_angle(angle_q, STEP_POS);
            end
          end else begin
            if (angle_q == AMIN) begin
              angle_d    = step_angle(angle_q, STEP_POS);
              dir_up_d   = 1'b1;
              sweep_done = 1'b1;
            end else begin
              angle_d = step_angle(angle_q, STEP_NEG);
            end
          end
`else
          if (angle_q == AMAX) begin
            angle_d    = AMIN;
            sweep_done = 1'b1;
          end else begin
            angle_d = step_angle(angle_q, STEP_POS);
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      timer_q  <= '0;
      thr_q    <= '0;
      tof_q    <= '0;
      hit_q    <= 1'b0;
      angle_q  <= AMIN;
`ifdef SCAN_PINGPONG_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      timer_q  <= timer_d;
      thr_q    <= thr_d;
      tof_q    <= tof_d;
      hit_q    <= hit_d;
      angle_q  <= angle_d;
`ifdef SCAN_PINGPONG_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign beam_angle_out          = angle_q;
  assign burst_active_out        = (state_q == S_BURST);
  assign listen_active_out       = (state_q == S_LISTEN);
  assign frontend_rst_out        = (state_q == S_BURST) && (timer_q == '0);
  assign time_since_emission_out = timer_q;
  assign result_valid_out        = (state_q == S_REPORT);
  // The record reads as zero whenever it is not being offered.
  assign result_angle_out        = result_valid_out ? angle_q : '0;
  assign result_tof_out          = result_valid_out ? tof_q : '0;
  assign result_hit_out          = result_valid_out & hit_q;
  assign sweep_done_out          = sweep_done;

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
module tb_sonar_scan_sequencer;

  localparam int TW = 7;

  logic                  clk;
  logic                  rst_n;
  logic                  enable_in;
  logic [15:0]           sample_in;
  logic                  sample_valid_in;
  logic [15:0]           threshold_in;
  logic signed [7:0]     beam_angle_out;
  logic                  burst_active_out;
  logic                  listen_active_out;
  logic                  frontend_rst_out;
  logic [TW-1:0]         time_since_emission_out;
  logic                  result_valid_out;
  logic                  result_ready_in;
  logic signed [7:0]     result_angle_out;
  logic [TW-1:0]         result_tof_out;
  logic                  result_hit_out;
  logic                  sweep_done_out;

  sonar_scan_sequencer #(
    .ANGLE_WIDTH(8), .ANGLE_MIN(-30), .ANGLE_MAX(30), .ANGLE_STEP(10),
    .SETTLE_CYCLES(2), .BURST_CYCLES(8), .LISTEN_CYCLES(64),
    .BLANK_CYCLES(4), .SAMPLE_WIDTH(16)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .enable_in(enable_in),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .threshold_in(threshold_in), .beam_angle_out(beam_angle_out),
    .burst_active_out(burst_active_out), .listen_active_out(listen_active_out),
    .frontend_rst_out(frontend_rst_out),
    .time_since_emission_out(time_since_emission_out),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_angle_out(result_angle_out), .result_tof_out(result_tof_out),
    .result_hit_out(result_hit_out), .sweep_done_out(sweep_done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One ping: up to three echo times (-1 = unused), echo magnitude, expected result.
  typedef struct {
    int   t0;
    int   t1;
    int   t2;
    int   val;
    logic hit;
    int   tof;
  } vec_t;

  typedef struct {
    logic signed [7:0] angle;
    logic [TW-1:0]     tof;
    logic              hit;
    logic              done;
  } rec_t;

  vec_t vecs [8];
  vec_t cur;
  rec_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rec_count = 0;
  int last_acc_cyc = 0;
  int burst_cnt = 0;
  int frst_cnt = 0;
  int k = 0;

  task automatic check_val(input string name, input logic signed [31:0] act,
                           input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [7:0] exp_angle(input int idx);
    int a;
`ifdef SCAN_PINGPONG_EN
    int p;
    p = idx % 12;
    a = (p <= 6) ? (-30 + 10 * p) : (30 - 10 * (p - 6));
`else
    a = -30 + 10 * (idx % 7);
`endif
    return 8'(a);
  endfunction

  function automatic logic exp_done(input int idx);
`ifdef SCAN_PINGPONG_EN
    int p;
    p = idx % 12;
    return (p == 6) || (p == 0 && idx > 0);
`else
    return (idx % 7) == 6;
`endif
  endfunction

  task automatic push_exp(input vec_t v);
    rec_t r;
    cur     = v;
    r.angle = exp_angle(k);
    r.tof   = TW'(v.tof);
    r.hit   = v.hit;
    r.done  = exp_done(k);
    k++;
    exp_q.push_back(r);
  endtask

  // Waits for the next accepted record, then steps past the accepting edge.
  task automatic wait_next();
    int start;
    int n;
    start = rec_count;
    n = 0;
    while (rec_count == start && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (rec_count == start) begin
      checks++; errors++;
      $display("FAIL record_timeout: no record within %0d cycles", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_listen_timer(input int t);
    int n;
    n = 0;
    while (!(listen_active_out && time_since_emission_out == TW'(t)) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL listen_timeout: timer %0d never reached", t);
    end
  endtask

  // Monitor / scoreboard: compares each accepted record against the queue.
  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        burst_cnt = 0;
        frst_cnt  = 0;
      end else begin
        if (frontend_rst_out) begin
          burst_cnt = 0;
          frst_cnt++;
        end
        if (burst_active_out) burst_cnt++;
        if (result_valid_out && result_ready_in) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_record: angle %0d tof %0d hit %0d",
                     result_angle_out, result_tof_out, result_hit_out);
          end else begin
            e = exp_q.pop_front();
            check_val("rec_angle", result_angle_out, e.angle);
            check_val("rec_tof", result_tof_out, e.tof);
            check_val("rec_hit", result_hit_out, e.hit);
            check_val("rec_sweep_done", sweep_done_out, e.done);
            check_val("burst_len", burst_cnt, 8);
            check_val("frontend_rst_pulses", frst_cnt, 1);
          end
          frst_cnt = 0;
          rec_count++;
          last_acc_cyc = cyc;
        end else if (sweep_done_out) begin
          check_val("stray_sweep_done", sweep_done_out, 0);
        end
      end
    end
  end

  // Receive-path driver: echoes at the scheduled timer values, sub-threshold
  // or unqualified noise everywhere else.
  initial begin : driver
    sample_valid_in = 1'b0;
    sample_in = '0;
    forever begin
      @(posedge clk); #1;
      if (listen_active_out &&
          (int'(time_since_emission_out) == cur.t0 ||
           int'(time_since_emission_out) == cur.t1 ||
           int'(time_since_emission_out) == cur.t2)) begin
        sample_valid_in = 1'b1;
        sample_in = 16'(cur.val);
      end else if ($urandom_range(0, 1) == 1) begin
        sample_valid_in = 1'b1;
        sample_in = 16'($urandom_range(0, 5000));
      end else begin
        sample_valid_in = 1'b0;
        sample_in = 16'hFFFF;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int bad;
    int gap;
    int n;
    rec_t e;

    vecs[0] = '{t0: -1, t1: -1, t2: -1, val: 0,    hit: 1'b0, tof: 0};
    vecs[1] = '{t0: 10, t1: 12, t2: 20, val: 6000, hit: 1'b1, tof: 12};
    vecs[2] = '{t0: 10, t1: 12, t2: 20, val: 5000, hit: 1'b0, tof: 0};
    vecs[3] = '{t0: 10, t1: -1, t2: -1, val: 6000, hit: 1'b0, tof: 0};
    vecs[4] = '{t0: 11, t1: -1, t2: -1, val: 6000, hit: 1'b0, tof: 0};
    vecs[5] = '{t0: 71, t1: -1, t2: -1, val: 6000, hit: 1'b1, tof: 71};
    vecs[6] = '{t0: 40, t1: 65, t2: -1, val: 5001, hit: 1'b1, tof: 40};
    vecs[7] = '{t0: 20, t1: -1, t2: -1, val: 6000, hit: 1'b1, tof: 20};
    cur = vecs[0];

    rst_n = 1'b0;
    enable_in = 1'b0;
    result_ready_in = 1'b1;
    threshold_in = 16'd5000;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_beam_angle", beam_angle_out, -30);
    check_val("rst_burst", burst_active_out, 0);
    check_val("rst_listen", listen_active_out, 0);
    check_val("rst_frontend_rst", frontend_rst_out, 0);
    check_val("rst_timer", time_since_emission_out, 0);
    check_val("rst_valid", result_valid_out, 0);
    check_val("rst_sweep_done", sweep_done_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with enable low: nothing happens.
    bad = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (burst_active_out || listen_active_out || result_valid_out) bad++;
    end
    check_val("idle_quiet", bad, 0);
    check_val("idle_angle", beam_angle_out, -30);

    // First sweep, one table row per angle.
    push_exp(vecs[0]);
    enable_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_next();
      if (i < 6) push_exp(vecs[i + 1]);
    end

    // Stalled consumer.
    result_ready_in = 1'b0;
    push_exp(vecs[7]);
    n = 0;
    while (!result_valid_out && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("stall_valid_seen", result_valid_out, 1);
    bad = 0;
    e = exp_q.size() > 0 ? exp_q[0] : '{angle: 8'sd0, tof: '0, hit: 1'b0, done: 1'b0};
    repeat (50) begin
      @(negedge clk); #1;
      if (!result_valid_out || result_angle_out !== e.angle || result_tof_out !== e.tof ||
          result_hit_out !== e.hit || burst_active_out || frontend_rst_out) bad++;
    end
    check_val("stall_record_stable", bad, 0);
    @(posedge clk); #1;
    result_ready_in = 1'b1;
    wait_next();
    push_exp(vecs[0]);
    gap = 0;
    n = 0;
    while (!frontend_rst_out && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    gap = cyc - last_acc_cyc;
    check_val("resume_gap", gap, 3);

    // Records 9..13, completing the pingpong return sweep when enabled.
    repeat (5) begin
      wait_next();
      push_exp(vecs[0]);
    end

    // Reset in the middle of a listen window.
    wait_listen_timer(40);
    rst_n = 1'b0;
    #1;
    check_val("midrst_beam_angle", beam_angle_out, -30);
    check_val("midrst_listen", listen_active_out, 0);
    check_val("midrst_burst", burst_active_out, 0);
    check_val("midrst_timer", time_since_emission_out, 0);
    check_val("midrst_valid", result_valid_out, 0);
    check_val("midrst_tof", result_tof_out, 0);
    exp_q.delete();
    k = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    push_exp(vecs[0]);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_next();
      push_exp(i < 2 ? vecs[0] : vecs[1]);
    end

    // Enable dropped mid-ping at angle 0: record still delivered, then idle.
    wait_listen_timer(30);
    enable_in = 1'b0;
    wait_next();
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (burst_active_out || listen_active_out || result_valid_out || frontend_rst_out) bad++;
    end
    check_val("disable_idle_quiet", bad, 0);
    check_val("disable_angle", beam_angle_out, 10);
    check_val("disable_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
